// File: rtl/seq_detect_multi.sv
// Serial pattern detector: flags when the last LEN accepted bits equal any of NPAT loadable patterns.
// Optional feature macro: SEQDET_CNT_EN builds the saturating match counter (tied to 0 otherwise).
module seq_detect_multi #(
  parameter int                      LEN      = 4,
  parameter int                      NPAT     = 2,
  parameter int                      CNT_W    = 8,
  parameter logic [NPAT*LEN-1:0]     PAT_INIT = {4'b1110, 4'b1101}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                A,
  input  logic                ovl,
  input  logic                load,
  input  logic [NPAT*LEN-1:0] pat_in,
  input  logic                clr_cnt,
  output logic [NPAT-1:0]     match,
  output logic                match_any,
  output logic [CNT_W-1:0]    match_cnt
);

  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] LEN_F = FW'(LEN);

  logic [LEN-1:0]      r_hist;
  logic [FW-1:0]       r_fill;
  logic [NPAT*LEN-1:0] r_pat;
  logic [NPAT-1:0]     r_match;

  logic [LEN-1:0]      w_hist_n;
  logic [FW-1:0]       w_fill_inc;
  logic [NPAT-1:0]     w_hit;
  logic [NPAT-1:0]     w_match_n;

  // Candidate window and per-pattern comparison for the bit being offered this cycle
  always_comb begin
    w_hist_n   = {r_hist[LEN-2:0], A};
    w_fill_inc = (r_fill == LEN_F) ? LEN_F : r_fill + {{(FW-1){1'b0}}, 1'b1};
    w_hit      = '0;
    for (int i = 0; i < NPAT; i++) begin
      w_hit[i] = (w_fill_inc == LEN_F) && (w_hist_n == r_pat[i*LEN +: LEN]);
    end
    if (load) begin
      w_match_n = '0;
    end else if (en) begin
      w_match_n = w_hit;
    end else begin
      w_match_n = '0;
    end
  end

  // History, fill level, pattern store and match pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= PAT_INIT;
      r_match <= '0;
    end else begin
      r_match <= w_match_n;
      if (load) begin
        r_pat  <= pat_in;
        r_fill <= '0;
      end else if (en) begin
        r_hist <= w_hist_n;
        // Non-overlapping: restart filling so no matched bit is reused
        r_fill <= (!ovl && (|w_hit)) ? '0 : w_fill_inc;
      end
    end
  end

  assign match     = r_match;
  assign match_any = |r_match;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Counts on the edge that registers a match so the count lines up with the visible pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if ((|w_match_n) && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign match_cnt = r_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_cnt;
  assign match_cnt    = '0;
`endif

endmodule
